// File: rtl/lsu_pkg.sv
// Shared LSU definitions: funct3 size/sign codes, FSM state encoding and byte-enable constants.
package lsu_pkg;

  localparam logic [2:0] F3Byte  = 3'b000;
  localparam logic [2:0] F3Half  = 3'b001;
  localparam logic [2:0] F3Word  = 3'b010;
  localparam logic [2:0] F3ByteU = 3'b100;
  localparam logic [2:0] F3HalfU = 3'b101;

  localparam logic [3:0] BeNone   = 4'b0000;
  localparam logic [3:0] BeByte0  = 4'b0001;
  localparam logic [3:0] BeLoHalf = 4'b0011;
  localparam logic [3:0] BeHiHalf = 4'b1100;
  localparam logic [3:0] BeAll    = 4'b1111;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDone
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store replication, byte-enable generation, load extraction/extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic        we_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  adr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    unique case (adr_lo_i)
      2'd0:    rbyte = rdata_i[7:0];
      2'd1:    rbyte = rdata_i[15:8];
      2'd2:    rbyte = rdata_i[23:16];
      default: rbyte = rdata_i[31:24];
    endcase
    rhalf = adr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  end

  // funct3[2] set means zero-extend; unlisted codes fall through to word behaviour.
  always_comb begin
    be_o    = BeAll;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (funct3_i)
      F3Byte, F3ByteU: begin
        if (we_i) be_o = BeByte0 << adr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{rbyte[7] & ~funct3_i[2]}}, rbyte};
      end
      F3Half, F3HalfU: begin
        if (we_i) be_o = adr_lo_i[1] ? BeHiHalf : BeLoHalf;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{rhalf[15] & ~funct3_i[2]}}, rhalf};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding bus access with sized, sign/zero-extended loads.
// Optional misalignment trap enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu
  import lsu_pkg::*;
(
  input  logic        CLK,
  input  logic        RES,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_adr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_busy,
  output logic        lsu_done,
  output logic [31:0] lsu_rdata,
  output logic        lsu_misalign,
  output logic        data_req,
  input  logic        data_gnt,
  input  logic        data_r_valid,
  output logic [31:0] data_adr,
  output logic [31:0] data_write,
  output logic        data_write_enable,
  output logic [3:0]  data_be,
  input  logic [31:0] data_read
);

  lsu_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [1:0]  adr_lo_q, adr_lo_d;
  logic [31:0] data_adr_q, data_adr_d;
  logic [31:0] data_write_q, data_write_d;
  logic        data_we_q, data_we_d;
  logic [3:0]  data_be_q, data_be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        data_req_q, data_req_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        idle;
  logic        misalign_req;
  logic        al_we;
  logic [2:0]  al_funct3;
  logic [1:0]  al_adr_lo;
  logic [3:0]  al_be;
  logic [31:0] al_wdata;
  logic [31:0] al_rdata;

  assign idle = (state_q == StIdle);

  // In IDLE the aligner shapes the incoming store; afterwards it decodes the latched load.
  assign al_we     = idle ? lsu_we : we_q;
  assign al_funct3 = idle ? lsu_funct3 : funct3_q;
  assign al_adr_lo = idle ? lsu_adr[1:0] : adr_lo_q;

  lsu_align u_align (
    .we_i     (al_we),
    .funct3_i (al_funct3),
    .adr_lo_i (al_adr_lo),
    .wdata_i  (lsu_wdata),
    .rdata_i  (data_read),
    .be_o     (al_be),
    .wdata_o  (al_wdata),
    .rdata_o  (al_rdata)
  );

`ifdef LSU_MISALIGN_TRAP_EN
  logic misalign_q, misalign_d;

  always_comb begin
    case (lsu_funct3)
      F3Byte, F3ByteU: misalign_req = 1'b0;
      F3Half, F3HalfU: misalign_req = lsu_adr[0];
      default:         misalign_req = |lsu_adr[1:0];
    endcase
  end

  assign misalign_d = idle & lsu_req & misalign_req;

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign lsu_misalign = misalign_q;
`else
  assign misalign_req = 1'b0;
  assign lsu_misalign = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    adr_lo_d     = adr_lo_q;
    data_adr_d   = data_adr_q;
    data_write_d = data_write_q;
    data_we_d    = data_we_q;
    data_be_d    = data_be_q;
    rdata_d      = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (lsu_req) begin
          we_d     = lsu_we;
          funct3_d = lsu_funct3;
          adr_lo_d = lsu_adr[1:0];
          if (misalign_req) begin
            state_d = StDone;
            rdata_d = '0;
          end else begin
            state_d      = StReq;
            data_adr_d   = {lsu_adr[31:2], 2'b00};
            data_write_d = al_wdata;
            data_we_d    = lsu_we;
            data_be_d    = al_be;
          end
        end
      end
      StReq: begin
        if (data_gnt) begin
          if (data_r_valid) begin
            state_d = StDone;
            if (!we_q) rdata_d = al_rdata;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (data_r_valid) begin
          state_d = StDone;
          if (!we_q) rdata_d = al_rdata;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    data_req_d = (state_d == StReq);
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
  end

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state_q      <= StIdle;
      we_q         <= 1'b0;
      funct3_q     <= F3Word;
      adr_lo_q     <= 2'b00;
      data_adr_q   <= '0;
      data_write_q <= '0;
      data_we_q    <= 1'b0;
      data_be_q    <= BeNone;
      rdata_q      <= '0;
      data_req_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      adr_lo_q     <= adr_lo_d;
      data_adr_q   <= data_adr_d;
      data_write_q <= data_write_d;
      data_we_q    <= data_we_d;
      data_be_q    <= data_be_d;
      rdata_q      <= rdata_d;
      data_req_q   <= data_req_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign lsu_busy          = busy_q;
  assign lsu_done          = done_q;
  assign lsu_rdata         = rdata_q;
  assign data_req          = data_req_q;
  assign data_adr          = data_adr_q;
  assign data_write        = data_write_q;
  assign data_write_enable = data_we_q;
  assign data_be           = data_be_q;

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed transactions checked every cycle against a behavioural model.
module tb_lsu;

  logic        CLK = 1'b0;
  logic        RES = 1'b0;
  logic        lsu_req = 1'b0;
  logic        lsu_we = 1'b0;
  logic [2:0]  lsu_funct3 = 3'b010;
  logic [31:0] lsu_adr = '0;
  logic [31:0] lsu_wdata = '0;
  logic        lsu_busy, lsu_done, lsu_misalign;
  logic [31:0] lsu_rdata;
  logic        data_req;
  logic        data_gnt = 1'b0;
  logic        data_r_valid = 1'b0;
  logic [31:0] data_adr, data_write, data_read;
  logic        data_write_enable;
  logic [3:0]  data_be;

  lsu dut (
    .CLK               (CLK),
    .RES               (RES),
    .lsu_req           (lsu_req),
    .lsu_we            (lsu_we),
    .lsu_funct3        (lsu_funct3),
    .lsu_adr           (lsu_adr),
    .lsu_wdata         (lsu_wdata),
    .lsu_busy          (lsu_busy),
    .lsu_done          (lsu_done),
    .lsu_rdata         (lsu_rdata),
    .lsu_misalign      (lsu_misalign),
    .data_req          (data_req),
    .data_gnt          (data_gnt),
    .data_r_valid      (data_r_valid),
    .data_adr          (data_adr),
    .data_write        (data_write),
    .data_write_enable (data_write_enable),
    .data_be           (data_be),
    .data_read         (data_read)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  // Expectations for the transaction in flight.
  bit          act = 1'b0;
  int          t_a, t_g, t_done;
  bit          t_mis, t_we;
  logic [31:0] t_adr, t_wr, t_rd;
  logic [3:0]  t_be;
  logic [31:0] held = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s @cyc %0d: got %h want %h", name, cyc, got, want);
  endtask

  // Size, lane and extension rules computed arithmetically.
  function automatic void model(input bit we, input logic [2:0] f3, input logic [31:0] adr,
                                input logic [31:0] wd, input logic [31:0] rd,
                                output logic [31:0] e_adr, output logic [31:0] e_wr,
                                output logic [31:0] e_rd, output logic [3:0] e_be,
                                output bit e_mis);
    int size, off;
    logic [31:0] mask, v;
    size  = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off   = (size == 1) ? int'(adr[1:0]) : (size == 2) ? 2 * int'(adr[1]) : 0;
    mask  = (size == 4) ? 32'hFFFF_FFFF : (32'h1 << (8 * size)) - 32'h1;
    e_adr = adr & ~32'h3;
    e_be  = we ? 4'(((1 << size) - 1) << off) : 4'hF;
    e_wr  = (wd & mask) * ((size == 1) ? 32'h0101_0101 : (size == 2) ? 32'h0001_0001 : 32'h1);
    v     = (rd >> (8 * off)) & mask;
    if (!f3[2] && size < 4 && v[8 * size - 1]) v = v | ~mask;
`ifdef LSU_MISALIGN_TRAP_EN
    e_mis = (size == 2 && adr[0]) || (size == 4 && adr[1:0] != 2'b00);
`else
    e_mis = 1'b0;
`endif
    e_rd = e_mis ? 32'h0 : v;
  endfunction

  task automatic compare();
    bit er, ed, eb;
    er = act && !t_mis && cyc >= t_a + 1 && cyc <= t_a + 1 + t_g;
    ed = act && cyc == t_done;
    eb = act && cyc >= t_a + 1 && cyc <= t_done;
    check("data_req", 32'(data_req), 32'(er));
    check("lsu_done", 32'(lsu_done), 32'(ed));
    check("lsu_busy", 32'(lsu_busy), 32'(eb));
    check("lsu_misalign", 32'(lsu_misalign), 32'(ed && t_mis));
    if (er) begin
      check("data_adr", data_adr, t_adr);
      check("data_be", 32'(data_be), 32'(t_be));
      check("data_write_enable", 32'(data_write_enable), 32'(t_we));
      if (t_we) check("data_write", data_write, t_wr);
    end
    if (ed && (!t_we || t_mis)) held = t_rd;
    check("lsu_rdata", lsu_rdata, held);
  endtask

  task automatic reset_checks();
    check("rst data_req", 32'(data_req), 32'h0);
    check("rst data_write_enable", 32'(data_write_enable), 32'h0);
    check("rst lsu_busy", 32'(lsu_busy), 32'h0);
    check("rst lsu_done", 32'(lsu_done), 32'h0);
    check("rst lsu_misalign", 32'(lsu_misalign), 32'h0);
    check("rst data_be", 32'(data_be), 32'h0);
    check("rst data_adr", data_adr, 32'h0);
    check("rst data_write", data_write, 32'h0);
    check("rst lsu_rdata", lsu_rdata, 32'h0);
  endtask

  // g = gnt-low REQ cycles, r = cycles from gnt to r_valid (0 = same cycle).
  task automatic run_txn(input bit we, input logic [2:0] f3, input logic [31:0] adr,
                         input logic [31:0] wd, input logic [31:0] rd, input int g,
                         input int r, input bit hold);
    int lat;
    model(we, f3, adr, wd, rd, t_adr, t_wr, t_rd, t_be, t_mis);
    @(posedge CLK); #1;
    lsu_req = 1'b1; lsu_we = we; lsu_funct3 = f3; lsu_adr = adr; lsu_wdata = wd;
    data_read = rd;
    lat = t_mis ? 1 : g + 2 + r;
    t_a = cyc; t_g = g; t_we = we; t_done = cyc + lat; act = 1'b1;
    for (int k = 1; k <= lat; k++) begin
      @(posedge CLK); #1;
      if (!hold || k == lat) lsu_req = 1'b0;
      lsu_we = ~we; lsu_funct3 = ~f3; lsu_adr = ~adr; lsu_wdata = ~wd;
      data_gnt     = !t_mis && (k == g + 1);
      data_r_valid = !t_mis && ((k <= g) || (k == g + 1 + r));
    end
    @(posedge CLK); #1;
    act = 1'b0;
  endtask

  logic [31:0] p_adr, p_wr, p_rd;
  logic [3:0]  p_be;
  bit          p_mis;

  initial begin
    #1 RES = 1'b1;
    #1 reset_checks();

    model(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, p_adr, p_wr, p_rd, p_be, p_mis);
    check("pin lw adr", p_adr, 32'h100);
    check("pin lw be", 32'(p_be), 32'hF);
    check("pin lw rdata", p_rd, 32'hDEAD_BEEF);
    model(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, p_adr, p_wr, p_rd, p_be, p_mis);
    check("pin lb rdata", p_rd, 32'hFFFF_FF80);
    model(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, p_adr, p_wr, p_rd, p_be, p_mis);
    check("pin lbu rdata", p_rd, 32'h0000_0080);
    model(1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, p_adr, p_wr, p_rd, p_be, p_mis);
    check("pin sh adr", p_adr, 32'h200);
    check("pin sh be", 32'(p_be), 32'hC);
    check("pin sh wdata", p_wr, 32'hABCD_ABCD);

    repeat (2) @(posedge CLK);
    #2 RES = 1'b0;

    fork
      forever begin
        @(negedge CLK);
        if (!RES) compare();
      end
      begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
      end
    join_none

    run_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1, 1'b0);
    check("lw held rdata", lsu_rdata, 32'hDEAD_BEEF);
    run_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF_1234, 0, 0, 1'b0);
    run_txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF_1234, 1, 2, 1'b0);
    check("lbu held rdata", lsu_rdata, 32'h0000_0080);
    run_txn(1'b1, 3'b001, 32'h202, 32'h0000_ABCD, 32'h0, 3, 1, 1'b0);
    run_txn(1'b1, 3'b000, 32'h101, 32'h1234_5678, 32'h0, 0, 0, 1'b1);
    run_txn(1'b0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 2, 0, 1'b0);
    run_txn(1'b0, 3'b101, 32'h100, 32'h0, 32'h8001_7FFF, 0, 3, 1'b1);
    run_txn(1'b1, 3'b010, 32'h204, 32'hCAFE_F00D, 32'h0, 1, 1, 1'b0);
    run_txn(1'b0, 3'b011, 32'h108, 32'h0, 32'h0BAD_CAFE, 0, 0, 1'b0);
    run_txn(1'b0, 3'b010, 32'h102, 32'h0, 32'h1357_9BDF, 0, 1, 1'b0);

    // Reset while waiting for r_valid; the late r_valid must be ignored.
    @(posedge CLK); #1;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_funct3 = 3'b010; lsu_adr = 32'h300;
    data_read = 32'h1111_2222;
    t_a = cyc; t_g = 0; t_mis = 1'b0; t_we = 1'b0; t_adr = 32'h300; t_be = 4'hF;
    t_done = cyc + 50; act = 1'b1;
    @(posedge CLK); #1;
    lsu_req = 1'b0; data_gnt = 1'b1;
    @(posedge CLK); #1;
    data_gnt = 1'b0;
    #2 RES = 1'b1; act = 1'b0; held = '0;
    #1 reset_checks();
    @(posedge CLK); #2;
    RES = 1'b0;
    data_r_valid = 1'b1;
    repeat (3) @(posedge CLK);
    #1 data_r_valid = 1'b0;

    run_txn(1'b0, 3'b000, 32'h402, 32'h0, 32'h00A5_0000, 0, 0, 1'b0);
    check("post-reset lb", lsu_rdata, 32'hFFFF_FFA5);

    repeat (2) @(posedge CLK);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
